// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing for a classic 5-stage core.
// Drives PC / IF/ID write enables, the IF/ID flush, the ID/EX bubble and the
// whole-pipe freeze from load-use hazards, taken branches and data-memory waits.
// Optional build macro: PERF_CNT_EN adds saturating stall/flush/memwait counters.
module hazard_stall_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,   // 1..7
  parameter int unsigned MEM_TIMEOUT       = 255  // 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic        mem_err,
`ifdef PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] memwait_cnt,
`endif
  output logic [1:0]  state
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;

  // Extra bubbles after the first one, taken in LDSTALL.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [8:0] TMO_LIMIT    = 9'(MEM_TIMEOUT);
  localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);

  logic [1:0] state_q, state_d;
  logic [2:0] scnt_q, scnt_d;     // remaining LDSTALL cycles, held across MEMWAIT
  logic [7:0] tcnt_q, tcnt_d;     // consecutive memory-wait cycles
  logic       mem_err_q, mem_err_d;

  logic       hz_s;
  logic       mw_s;
  logic [8:0] tcnt_inc_s;

  // Hazard and memory-wait terms shared by next-state and output logic.
  always_comb begin
    hz_s = idex_memread & (idex_rt != 5'd0) &
           ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));
    mw_s = dmem_req & ~dmem_ready;
    tcnt_inc_s = {1'b0, tcnt_q} + 9'd1;
  end

  // State, counters and sticky error register; reset also aborts any stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      scnt_q    <= 3'd0;
      tcnt_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      tcnt_q    <= tcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state and counter update; memory wait beats load-use beats branch.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    tcnt_d    = tcnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (mw_s) begin
          // A one-cycle limit expires on the very first wait cycle.
          if (TMO_LIMIT <= 9'd1) begin
            mem_err_d = 1'b1;
            state_d   = ST_RUN;
            tcnt_d    = 8'd0;
          end else begin
            state_d = ST_MEMWAIT;
            tcnt_d  = 8'd1;
          end
        end else if (hz_s) begin
          if (MULTI_STALL) begin
            state_d = ST_LDSTALL;
            scnt_d  = STALL_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LDSTALL: begin
        if (mw_s) begin
          // Stall count is frozen while memory is waited on.
          if (TMO_LIMIT <= 9'd1) begin
            mem_err_d = 1'b1;
            state_d   = ST_RUN;
            scnt_d    = 3'd0;
            tcnt_d    = 8'd0;
          end else begin
            state_d = ST_MEMWAIT;
            tcnt_d  = 8'd1;
          end
        end else if (scnt_q <= 3'd1) begin
          state_d = ST_RUN;
          scnt_d  = 3'd0;
        end else begin
          scnt_d = scnt_q - 3'd1;
        end
      end
      ST_MEMWAIT: begin
        if (dmem_ready) begin
          state_d = (scnt_q != 3'd0) ? ST_LDSTALL : ST_RUN;
          tcnt_d  = 8'd0;
        end else if (tcnt_inc_s >= TMO_LIMIT) begin
          // Give up on the access: flag it and restart the pipe cleanly.
          mem_err_d = 1'b1;
          state_d   = ST_RUN;
          scnt_d    = 3'd0;
          tcnt_d    = 8'd0;
        end else begin
          tcnt_d = tcnt_inc_s[7:0];
        end
      end
      default: begin
        state_d = ST_RUN;
        scnt_d  = 3'd0;
        tcnt_d  = 8'd0;
      end
    endcase
  end

  // Pipeline control outputs, combinational from state, reset and inputs.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (reset) begin
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mw_s) begin
            pipe_freeze = 1'b1;
          end else if (hz_s) begin
            idex_bubble = 1'b1;
          end else if (branch_taken) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        ST_LDSTALL: begin
          if (mw_s) begin
            pipe_freeze = 1'b1;
          end else begin
            idex_bubble = 1'b1;
          end
        end
        ST_MEMWAIT: begin
          if (dmem_ready) begin
            pipe_freeze = 1'b0;
          end else begin
            pipe_freeze = 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: hold front end and inject a nop.
          idex_bubble = 1'b1;
        end
      endcase
    end
  end

  // Registered status outputs; state reads RUN while reset is held.
  always_comb begin
    mem_err = mem_err_q;
    if (reset) begin
      state = ST_RUN;
    end else begin
      state = state_q;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q   <= 32'd0;
      flush_cnt_q   <= 32'd0;
      memwait_cnt_q <= 32'd0;
    end else begin
      if (idex_bubble && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
      if (pipe_freeze && (memwait_cnt_q != 32'hFFFF_FFFF)) begin
        memwait_cnt_q <= memwait_cnt_q + 32'd1;
      end
    end
  end

  // Expose the counters.
  always_comb begin
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
    memwait_cnt = memwait_cnt_q;
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances (LOAD_STALL_CYCLES 1/3/4,
// MEM_TIMEOUT 5) share one stimulus stream; build with PERF_CNT_EN for counters.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       idex_memread;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       ifid_uses_rt, branch_taken, dmem_req, dmem_ready;

  logic [2:0] pcw, ifw, flu, bub, frz, merr;
  logic [1:0] st [3];
`ifdef PERF_CNT_EN
  logic [31:0] stall_c [3];
  logic [31:0] flush_c [3];
  logic [31:0] mw_c [3];
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned LSC = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      hazard_stall_ctrl #(.LOAD_STALL_CYCLES(LSC), .MEM_TIMEOUT(5)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_write     (pcw[g]),
        .ifid_write   (ifw[g]),
        .ifid_flush   (flu[g]),
        .idex_bubble  (bub[g]),
        .pipe_freeze  (frz[g]),
        .mem_err      (merr[g]),
`ifdef PERF_CNT_EN
        .stall_cnt    (stall_c[g]),
        .flush_cnt    (flush_c[g]),
        .memwait_cnt  (mw_c[g]),
`endif
        .state        (st[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change right after the falling edge; checks land 3 units before the rising edge.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_in();
    idex_memread = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    ifid_uses_rt = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();

    // 1. reset for two cycles, then idle
    nxt(); #2;
    chk("rst_pcw", pcw[0], 32'd0); chk("rst_ifw", ifw[0], 32'd0);
    chk("rst_bub", bub[0], 32'd1); chk("rst_state", st[0], 32'd0);
    nxt(); #2;
    chk("rst2_pcw", pcw[0], 32'd0); chk("rst2_bub", bub[0], 32'd1);
    nxt(); reset = 1'b0; #2;
    chk("run_state", st[0], 32'd0); chk("run_pcw", pcw[0], 32'd1);
    chk("run_ifw", ifw[0], 32'd1); chk("run_merr", merr[0], 32'd0);
    chk("run_bub", bub[0], 32'd0); chk("run_frz", frz[0], 32'd0);

    // 2. single-cycle load-use stall on Rs
    nxt(); idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; #2;
    chk("lu1_pcw", pcw[0], 32'd0); chk("lu1_bub", bub[0], 32'd1);
    chk("lu1_ifw", ifw[0], 32'd0); chk("lu1_state", st[0], 32'd0);
    nxt(); idle_in(); #2;
    chk("lu1_resume_pcw", pcw[0], 32'd1); chk("lu1_resume_bub", bub[0], 32'd0);
    chk("lu3_enter_state", st[1], 32'd1); chk("lu3_enter_bub", bub[1], 32'd1);
    repeat (4) nxt();
    #2;
    chk("settle_st1", st[1], 32'd0); chk("settle_st2", st[2], 32'd0);

    // clear counters before the multi-cycle stall scenario
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;

    // 3. three-cycle stall via Rt
    nxt(); idex_memread = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; ifid_uses_rt = 1'b1; #2;
    chk("lu3_a_bub", bub[1], 32'd1); chk("lu3_a_pcw", pcw[1], 32'd0);
    chk("lu3_a_state", st[1], 32'd0); chk("lu1_rt_bub", bub[0], 32'd1);
    nxt(); idle_in(); #2;
    chk("lu3_b_state", st[1], 32'd1); chk("lu3_b_bub", bub[1], 32'd1);
    chk("lu3_b_pcw", pcw[1], 32'd0); chk("lu1_b_bub", bub[0], 32'd0); chk("lu1_b_pcw", pcw[0], 32'd1);
    nxt(); #2;
    chk("lu3_c_state", st[1], 32'd1); chk("lu3_c_bub", bub[1], 32'd1);
    nxt(); #2;
    chk("lu3_d_state", st[1], 32'd0); chk("lu3_d_bub", bub[1], 32'd0);
    chk("lu3_d_pcw", pcw[1], 32'd1); chk("lu4_d_state", st[2], 32'd1);
    nxt(); #2;
    chk("lu4_e_state", st[2], 32'd0);
`ifdef PERF_CNT_EN
    chk("perf_stall3", stall_c[1], 32'd3); chk("perf_stall4", stall_c[2], 32'd4);
    chk("perf_flush3", flush_c[1], 32'd0);
`endif
    // load into r0 never stalls
    nxt(); idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b1; #2;
    chk("r0_bub", bub[1], 32'd0); chk("r0_pcw", pcw[1], 32'd1); chk("r0_bub_l1", bub[0], 32'd0);
    // Rt match ignored when Rt is not a source
    nxt(); idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; ifid_uses_rt = 1'b0; #2;
    chk("rt_unused_bub", bub[1], 32'd0); chk("rt_unused_pcw", pcw[1], 32'd1);

    // 4. branch flush, and hazard priority over branch
    nxt(); idle_in(); branch_taken = 1'b1; #2;
    chk("br_flush", flu[0], 32'd1); chk("br_pcw", pcw[0], 32'd1);
    chk("br_ifw", ifw[0], 32'd1); chk("br_bub", bub[0], 32'd0);
    nxt(); branch_taken = 1'b0; #2;
    chk("br_off_flush", flu[0], 32'd0);
    nxt(); branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; #2;
    chk("brhz_flush", flu[0], 32'd0); chk("brhz_bub", bub[0], 32'd1);
    chk("brhz_pcw", pcw[0], 32'd0); chk("brhz_flush_l3", flu[1], 32'd0);
    nxt(); idex_memread = 1'b0; #2;
    chk("brld_state", st[1], 32'd1); chk("brld_flush", flu[1], 32'd0);
    chk("brld_bub", bub[1], 32'd1); chk("br_after_flush_l1", flu[0], 32'd1);
    nxt(); idle_in();
    repeat (3) nxt();
    #2;
    chk("br_settle_st1", st[1], 32'd0); chk("br_settle_st2", st[2], 32'd0);

    // 5. four-cycle memory wait then ready
    nxt(); dmem_req = 1'b1; dmem_ready = 1'b0; #2;
    chk("mw1_frz", frz[0], 32'd1); chk("mw1_pcw", pcw[0], 32'd0);
    chk("mw1_ifw", ifw[0], 32'd0); chk("mw1_bub", bub[0], 32'd0); chk("mw1_state", st[0], 32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #2;
      chk("mw_state", st[0], 32'd2); chk("mw_frz", frz[0], 32'd1); chk("mw_flush", flu[0], 32'd0);
    end
    nxt(); dmem_ready = 1'b1; #2;
    chk("mwrdy_frz", frz[0], 32'd0); chk("mwrdy_pcw", pcw[0], 32'd0);
    chk("mwrdy_ifw", ifw[0], 32'd0); chk("mwrdy_state", st[0], 32'd2);
    nxt(); idle_in(); #2;
    chk("mwdone_state", st[0], 32'd0); chk("mwdone_pcw", pcw[0], 32'd1); chk("mwdone_merr", merr[0], 32'd0);

    // 5b. timeout after five frozen cycles
    nxt(); dmem_req = 1'b1; #2;
    chk("tmo1_frz", frz[0], 32'd1);
    for (int i = 0; i < 4; i++) begin
      nxt(); #2;
      chk("tmo_state", st[0], 32'd2); chk("tmo_merr_low", merr[0], 32'd0);
    end
    nxt(); dmem_req = 1'b0; #2;
    chk("tmo_merr", merr[0], 32'd1); chk("tmo_state_run", st[0], 32'd0);
    chk("tmo_pcw", pcw[0], 32'd1); chk("tmo_merr_l4", merr[2], 32'd1);
    nxt(); #2;
    chk("tmo_sticky", merr[0], 32'd1);

    // 6. reset in the second LDSTALL cycle of the four-cycle stall
    nxt(); idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; #2;
    chk("lu4_a_bub", bub[2], 32'd1);
    nxt(); idle_in(); #2;
    chk("lu4_b_state", st[2], 32'd1);
    nxt(); reset = 1'b1; #2;
    chk("lu4_rst_state", st[2], 32'd0); chk("lu4_rst_bub", bub[2], 32'd1); chk("lu4_rst_pcw", pcw[2], 32'd0);
    nxt(); reset = 1'b0; #2;
    chk("lu4_post_state", st[2], 32'd0); chk("lu4_post_pcw", pcw[2], 32'd1);
    chk("lu4_post_bub", bub[2], 32'd0); chk("post_merr_clr", merr[0], 32'd0);
    nxt(); idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; #2;
    chk("lu4_again_bub", bub[2], 32'd1);
    nxt(); idle_in(); #2;
    chk("lu4_again_state", st[2], 32'd1);
    repeat (4) nxt();
    #2;
    chk("lu4_final_state", st[2], 32'd0); chk("lu4_final_pcw", pcw[2], 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Sequences the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards and inserts one or more bubbles into ID/EX.
- Flushes IF/ID on a taken branch.
- Freezes the whole pipe while data memory is not ready.
- Sits beside the pipeline registers and drives their write-enable, flush and bubble controls.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 255, max consecutive MEMWAIT cycles before mem_err is raised (1..255)

Ports:
clk  input  1  clock; state updates on posedge
reset  input  1  synchronous, active-high
idex_memread  input  1  MemRead of the instruction currently in EX
idex_rt  input  5  Rt of the instruction in EX (load destination)
ifid_rs  input  5  Rs of the instruction in ID
ifid_rt  input  5  Rt of the instruction in ID
ifid_uses_rt  input  1  the ID instruction reads Rt as a source
branch_taken  input  1  branch resolved taken in ID
dmem_req  input  1  MEM stage is accessing data memory this cycle
dmem_ready  input  1  data memory completes the access this cycle
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID load zeros (nop)
idex_bubble  output  1  ID/EX loads all-zero control fields
pipe_freeze  output  1  hold ID/EX, EX/MEM, MEM/WB contents
mem_err  output  1  sticky memory-timeout flag
state  output  2  0=RUN, 1=LDSTALL, 2=MEMWAIT

Behaviour:
- Hazard term: hz = idex_memread & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
- Memory stall term: mw = dmem_req & ~dmem_ready.
- Outputs are combinational from state, reset and inputs. State, stall counter, timeout counter and mem_err are registered on posedge clk.
- While reset=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, pipe_freeze=0, state=RUN. On the next edge: counters clear and mem_err clears. Reset mid-stall aborts the stall immediately.
- Priority in every state: mw > hz > branch_taken.
- RUN:
  - mw: pc_write=0, ifid_write=0, pipe_freeze=1, idex_bubble=0; next state MEMWAIT; timeout counter=1.
  - else hz: pc_write=0, ifid_write=0, idex_bubble=1. If LOAD_STALL_CYCLES>1, next state LDSTALL with stall counter=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
  - else branch_taken: ifid_flush=1, pc_write=1, ifid_write=1 for exactly that cycle.
  - else: pc_write=1, ifid_write=1, all other controls 0.
- LDSTALL:
  - pc_write=0, ifid_write=0, idex_bubble=1; branch_taken is ignored.
  - Counter decrements each cycle; when it reaches 1, next state is RUN.
  - If mw occurs, MEMWAIT takes over and the counter is held. On return from MEMWAIT, the state goes to LDSTALL if counter>0, else RUN.
- MEMWAIT:
  - pc_write=0, ifid_write=0, pipe_freeze=1; no bubble, no flush.
  - On dmem_ready=1: all controls drop that same cycle and the next state is the resume state.
  - Timeout counter increments per cycle. When it reaches MEM_TIMEOUT, mem_err sets (sticky until reset) and the state is forced to RUN.
- State encoding 3 is illegal; it recovers to RUN on the next edge.
- ifid_flush and ifid_write are never both active with pipe_freeze.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs stall_cnt[31:0], flush_cnt[31:0] and memwait_cnt[31:0].
  - stall_cnt increments on each cycle with idex_bubble=1 while not in reset.
  - flush_cnt increments on each cycle with ifid_flush=1.
  - memwait_cnt increments on each cycle with pipe_freeze=1.
  - All three saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
1. reset=1 for 2 cycles, then idle → during reset pc_write=0, idex_bubble=1; after reset, state=0, pc_write=1, ifid_write=1, mem_err=0.
2. idex_memread=1, idex_rt=8, ifid_rs=8, LOAD_STALL_CYCLES=1 → one cycle with pc_write=0, idex_bubble=1; clear idex_memread → pc_write=1 the next cycle.
3. LOAD_STALL_CYCLES=3, hazard on ifid_rt=9 with ifid_uses_rt=1 → exactly 3 cycles of idex_bubble=1; hazard with idex_rt=0 → no stall.
4. branch_taken=1 with no hazard → ifid_flush=1 for 1 cycle; branch_taken=1 together with hz → no flush, stall only.
5. dmem_req=1, dmem_ready=0 for 4 cycles, then ready → pipe_freeze=1 for 4 cycles and 0 on the ready cycle. With MEM_TIMEOUT=5 and no ready → mem_err=1 after 5 cycles, state=0.
6. reset asserted in the 2nd cycle of LDSTALL (LOAD_STALL_CYCLES=4) → state=0 next edge and normal flow afterwards. With PERF_CNT_EN, scenario 3 leaves stall_cnt=3.
